// File: rtl/uart_port.sv
// uart_port: host-bus UART with one transmit holding register and one receive buffer.
// Frame format is 8N1, LSB first. Every bit lasts CLKS_PER_BIT cycles of CLK.
// Ports:
//   CLK, RST          clock; asynchronous active-low reset
//   rdn, wrn          active-low host read/write strobes, edge-detected
//   din               write data, captured into THR on an accepted write
//   dout, dout_oe     receive buffer (RBR) contents; tristate enable while rdn is low
//   data_ready        RBR holds an unread byte
//   tbre, tsre        THR empty; shift register empty and line idle
//   rx_overrun        sticky: an unread byte was overwritten
//   rx_frame_err      sticky: a frame had stop bit = 0
//   txd, rxd          serial lines, idle high
module uart_port #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       rdn,
  input  logic       wrn,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       dout_oe,
  output logic       data_ready,
  output logic       tbre,
  output logic       tsre,
  output logic       rx_overrun,
  output logic       rx_frame_err,
  output logic       txd,
  input  logic       rxd
);

  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_HALF = CW'(CLKS_PER_BIT / 2);

  // Host strobe sampling; a strobe is accepted on its registered falling edge.
  logic rd_s, rd_p, wr_s, wr_p;
  logic rd_acc, wr_acc;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_s    <= 1'b1;
      rd_p    <= 1'b1;
      wr_s    <= 1'b1;
      wr_p    <= 1'b1;
      dout_oe <= 1'b0;
    end else begin
      rd_s    <= rdn;
      rd_p    <= rd_s;
      wr_s    <= wrn;
      wr_p    <= wr_s;
      dout_oe <= ~rdn;
    end
  end

  assign rd_acc = rd_p & ~rd_s;
  assign wr_acc = wr_p & ~wr_s;

  // ---------------------------------------------------------------- transmit
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;

  tx_state_t     tx_state, tx_next;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_idx;
  logic [7:0]    thr, tsr;
  logic          tx_bit_end;
  logic          tx_load, tx_shift, tx_cnt_clr;
  logic          txd_d, tsre_d;

  assign tx_bit_end = (tx_cnt == BIT_LAST);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) tx_state <= T_IDLE;
    else      tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      T_IDLE:  if (!tbre) tx_next = T_START;
      T_START: if (tx_bit_end) tx_next = T_DATA;
      T_DATA:  if (tx_bit_end && tx_idx == 3'd7) tx_next = T_STOP;
      T_STOP:  if (tx_bit_end) tx_next = tbre ? T_IDLE : T_START;
      default: tx_next = T_IDLE;
    endcase
  end

  // tsr[0] is always the bit on the line during T_DATA; txd_d looks one bit ahead.
  always_comb begin
    tx_load    = 1'b0;
    tx_shift   = 1'b0;
    tx_cnt_clr = tx_bit_end;
    txd_d      = txd;
    tsre_d     = tsre;
    case (tx_state)
      T_IDLE: begin
        tx_cnt_clr = 1'b1;
        if (!tbre) begin
          tx_load = 1'b1;
          txd_d   = 1'b0;
          tsre_d  = 1'b0;
        end
      end
      T_START: if (tx_bit_end) txd_d = tsr[0];
      T_DATA: begin
        tx_shift = tx_bit_end;
        if (tx_bit_end) txd_d = (tx_idx == 3'd7) ? 1'b1 : tsr[1];
      end
      T_STOP: begin
        if (tx_bit_end) begin
          if (!tbre) begin
            tx_load = 1'b1;
            txd_d   = 1'b0;
          end else begin
            tsre_d = 1'b1;
          end
        end
      end
      default: tx_cnt_clr = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tx_cnt <= '0;
      tx_idx <= '0;
      thr    <= '0;
      tsr    <= '0;
      tbre   <= 1'b1;
      tsre   <= 1'b1;
      txd    <= 1'b1;
    end else begin
      txd    <= txd_d;
      tsre   <= tsre_d;
      tx_cnt <= tx_cnt_clr ? '0 : tx_cnt + CW'(1);
      if (tx_shift) tx_idx <= tx_idx + 3'd1;
      else if (tx_state != T_DATA) tx_idx <= '0;
      if (tx_load) tsr <= thr;
      else if (tx_shift) tsr <= {1'b0, tsr[7:1]};
      // Load needs THR full, accepting a write needs it empty: never both.
      if (tx_load) begin
        tbre <= 1'b1;
      end else if (wr_acc && tbre) begin
        thr  <= din;
        tbre <= 1'b0;
      end
    end
  end

  // ----------------------------------------------------------------- receive
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  rx_state_t     rx_state, rx_next;
  logic          rx_meta, rx_s;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_idx;
  logic [7:0]    rsr;
  logic          rx_bit_end, rx_mid;
  logic          rx_cnt_clr, rx_shift, rx_done_ok, rx_done_bad;

  assign rx_bit_end = (rx_cnt == BIT_LAST);
  assign rx_mid     = (rx_cnt == BIT_HALF);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) rx_state <= R_IDLE;
    else      rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      R_IDLE:  if (!rx_s) rx_next = R_START;
      R_START: if (rx_mid) rx_next = rx_s ? R_IDLE : R_DATA;
      R_DATA:  if (rx_bit_end && rx_idx == 3'd7) rx_next = R_STOP;
      R_STOP:  if (rx_bit_end) rx_next = R_IDLE;
      default: rx_next = R_IDLE;
    endcase
  end

  // After the mid-start sample the counter restarts, so later samples land mid-bit.
  always_comb begin
    rx_cnt_clr  = 1'b0;
    rx_shift    = 1'b0;
    rx_done_ok  = 1'b0;
    rx_done_bad = 1'b0;
    case (rx_state)
      R_IDLE:  rx_cnt_clr = 1'b1;
      R_START: rx_cnt_clr = rx_mid;
      R_DATA: begin
        rx_cnt_clr = rx_bit_end;
        rx_shift   = rx_bit_end;
      end
      R_STOP: begin
        rx_cnt_clr  = rx_bit_end;
        rx_done_ok  = rx_bit_end & rx_s;
        rx_done_bad = rx_bit_end & ~rx_s;
      end
      default: rx_cnt_clr = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_meta      <= 1'b1;
      rx_s         <= 1'b1;
      rx_cnt       <= '0;
      rx_idx       <= '0;
      rsr          <= '0;
      dout         <= '0;
      data_ready   <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_meta <= rxd;
      rx_s    <= rx_meta;
      rx_cnt  <= rx_cnt_clr ? '0 : rx_cnt + CW'(1);
      if (rx_shift) begin
        rsr    <= {rx_s, rsr[7:1]};
        rx_idx <= rx_idx + 3'd1;
      end else if (rx_state != R_DATA) begin
        rx_idx <= '0;
      end
      if (rx_done_ok) dout <= rsr;
      // A read in the same cycle as a completion consumes the old byte: no overrun.
      data_ready   <= rx_done_ok | (data_ready & ~rd_acc);
      rx_overrun   <= (rx_done_ok & data_ready & ~rd_acc) | (rx_overrun & ~rd_acc);
      rx_frame_err <= rx_done_bad | (rx_frame_err & ~rd_acc);
    end
  end

endmodule

// File: tb/tb_uart_port.sv
module tb_uart_port;

  localparam int CPB   = 16;
  localparam int FRAME = 10 * CPB;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       rdn = 1'b1;
  logic       wrn = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;
  logic       dout_oe, data_ready, tbre, tsre, rx_overrun, rx_frame_err, txd;

  uart_port #(.CLKS_PER_BIT(CPB)) dut (
    .CLK(CLK), .RST(RST), .rdn(rdn), .wrn(wrn), .din(din),
    .dout(dout), .dout_oe(dout_oe), .data_ready(data_ready),
    .tbre(tbre), .tsre(tsre), .rx_overrun(rx_overrun),
    .rx_frame_err(rx_frame_err), .txd(txd), .rxd(rxd)
  );

  initial forever #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // Behavioural model: strobe history, THR as a full flag, the line as a
  // 10-bit frame indexed by elapsed cycles, RX as a queue of expected frames.
  logic       m_wr_s, m_wr_p, m_rd_s, m_rd_p;
  logic       m_wr_acc, m_rd_acc, m_thr_was_full;
  logic       m_thr_full, m_busy;
  logic [7:0] m_thr;
  logic [9:0] m_frame;
  int         m_pos;
  logic [7:0] m_rbr;
  logic       m_dr, m_ov, m_fe;
  int         rxq_at[$];
  logic [7:0] rxq_byte[$];
  logic       rxq_stop[$];

  task automatic m_reset();
    m_wr_s = 1'b1; m_wr_p = 1'b1; m_rd_s = 1'b1; m_rd_p = 1'b1;
    m_thr_full = 1'b0; m_busy = 1'b0; m_thr = 8'h00; m_frame = 10'h3FF; m_pos = 0;
    m_rbr = 8'h00; m_dr = 1'b0; m_ov = 1'b0; m_fe = 1'b0;
    rxq_at.delete(); rxq_byte.delete(); rxq_stop.delete();
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge CLK or negedge RST);
      if (!RST) begin
        m_reset();
      end else begin
        cyc++;
        m_wr_acc       = m_wr_p && !m_wr_s;
        m_rd_acc       = m_rd_p && !m_rd_s;
        m_thr_was_full = m_thr_full;
        if (m_busy) begin
          m_pos++;
          if (m_pos == FRAME) begin
            if (m_thr_full) begin
              m_frame = {1'b1, m_thr, 1'b0}; m_pos = 0; m_thr_full = 1'b0;
            end else begin
              m_busy = 1'b0;
            end
          end
        end else if (m_thr_full) begin
          m_frame = {1'b1, m_thr, 1'b0}; m_pos = 0; m_busy = 1'b1; m_thr_full = 1'b0;
        end
        if (m_wr_acc && !m_thr_was_full) begin
          m_thr = din; m_thr_full = 1'b1;
        end
        if (m_rd_acc) begin
          m_dr = 1'b0; m_ov = 1'b0; m_fe = 1'b0;
        end
        if (rxq_at.size() > 0 && rxq_at[0] == cyc) begin
          if (rxq_stop[0]) begin
            m_ov = m_ov | m_dr; m_dr = 1'b1; m_rbr = rxq_byte[0];
          end else begin
            m_fe = 1'b1;
          end
          void'(rxq_at.pop_front()); void'(rxq_byte.pop_front()); void'(rxq_stop.pop_front());
        end
        m_wr_p = m_wr_s; m_wr_s = wrn;
        m_rd_p = m_rd_s; m_rd_s = rdn;
      end
    end
  end

  // Per-cycle comparison. RX results are unchecked during the last bit time of
  // an incoming frame, where the exact completion cycle is implementation detail.
  logic exp_txd;
  logic rx_masked;
  initial forever begin
    @(negedge CLK);
    exp_txd   = m_busy ? m_frame[4'(m_pos / CPB)] : 1'b1;
    rx_masked = (rxq_at.size() > 0) && (cyc >= rxq_at[0] - CPB);
    check("txd",     8'(txd),     8'(exp_txd));
    check("tbre",    8'(tbre),    8'(!m_thr_full));
    check("tsre",    8'(tsre),    8'(!m_busy));
    check("dout_oe", 8'(dout_oe), 8'(!m_rd_s));
    if (!rx_masked) begin
      check("dout",         dout,               m_rbr);
      check("data_ready",   8'(data_ready),     8'(m_dr));
      check("rx_overrun",   8'(rx_overrun),     8'(m_ov));
      check("rx_frame_err", 8'(rx_frame_err),   8'(m_fe));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    din = d; wrn = 1'b0;
    tick(1);
    wrn = 1'b1;
    tick(1);
  endtask

  task automatic rd();
    rdn = 1'b0;
    tick(1);
    check("lit_dout_oe_rd", 8'(dout_oe), 8'h01);
    tick(1);
    check("lit_dr_after_rd", 8'(data_ready), 8'h00);
    rdn = 1'b1;
    tick(2);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    rxq_at.push_back(cyc + FRAME); rxq_byte.push_back(b); rxq_stop.push_back(stop);
    rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[3'(i)];
      tick(CPB);
    end
    rxd = stop;
    tick(CPB);
    rxd = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  logic [9:0] pat;

  initial begin
    #2 RST = 1'b0;
    tick(3);
    check("lit_rst_txd",  8'(txd),        8'h01);
    check("lit_rst_tbre", 8'(tbre),       8'h01);
    check("lit_rst_tsre", 8'(tsre),       8'h01);
    check("lit_rst_dout", dout,           8'h00);
    check("lit_rst_dr",   8'(data_ready), 8'h00);
    RST = 1'b1;
    tick(3);

    // 0x55 from idle: tbre low one cycle, bit-exact line, tsre after 160 cycles
    pat = 10'b1010101010;
    din = 8'h55; wrn = 1'b0;
    tick(1);
    wrn = 1'b1;
    check("lit_tbre_pre", 8'(tbre), 8'h01);
    tick(1);
    check("lit_tbre_low", 8'(tbre), 8'h00);
    tick(1);
    check("lit_tbre_back", 8'(tbre), 8'h01);
    check("lit_tsre_busy", 8'(tsre), 8'h00);
    tick(8);
    for (int i = 0; i < 10; i++) begin
      check("lit_txd_55", 8'(txd), 8'(pat[4'(i)]));
      if (i < 9) tick(CPB);
    end
    tick(7);
    check("lit_tsre_159", 8'(tsre), 8'h00);
    tick(1);
    check("lit_tsre_160", 8'(tsre), 8'h01);
    tick(5);

    // back-to-back 0xA5, 0x3C; third write while THR full is dropped
    wr(8'hA5);
    tick(3);
    wr(8'h3C);
    check("lit_thr_full", 8'(tbre), 8'h00);
    wr(8'h99);
    check("lit_thr_still", 8'(tbre), 8'h00);
    tick(2 * FRAME + 10);
    check("lit_idle_after2", 8'(tsre), 8'h01);

    // receive 0xC3 and read it
    send_rx(8'hC3, 1'b1);
    tick(2);
    check("lit_c3_dr",   8'(data_ready), 8'h01);
    check("lit_c3_dout", dout,           8'hC3);
    rd();
    check("lit_c3_dout_keep", dout, 8'hC3);

    // overrun: 0x11 then 0x22 unread
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    tick(2);
    check("lit_ov_dout", dout,           8'h22);
    check("lit_ov_flag", 8'(rx_overrun), 8'h01);
    check("lit_ov_dr",   8'(data_ready), 8'h01);
    rd();
    check("lit_ov_clr", 8'(rx_overrun), 8'h00);

    // glitch is a false start; then a framing error leaves RBR alone
    rxd = 1'b0;
    tick(5);
    rxd = 1'b1;
    tick(30);
    check("lit_glitch_dr", 8'(data_ready),   8'h00);
    check("lit_glitch_fe", 8'(rx_frame_err), 8'h00);
    send_rx(8'h7E, 1'b0);
    tick(30);
    check("lit_fe_flag", 8'(rx_frame_err), 8'h01);
    check("lit_fe_dr",   8'(data_ready),   8'h00);
    check("lit_fe_rbr",  dout,             8'h22);
    rd();
    check("lit_fe_clr", 8'(rx_frame_err), 8'h00);

    // TX and RX together, then simultaneous read and write
    fork
      send_rx(8'hA9, 1'b1);
      begin
        tick(20);
        wr(8'h96);
      end
    join
    tick(CPB);
    din = 8'h42; rdn = 1'b0; wrn = 1'b0;
    tick(1);
    wrn = 1'b1;
    tick(2);
    rdn = 1'b1;
    check("lit_sim_dr", 8'(data_ready), 8'h00);
    tick(FRAME + 5);

    // reset in the middle of bit 4 of a frame
    wr(8'hF0);
    tick(1 + 4 * CPB + 8);
    #2 RST = 1'b0;
    #1;
    check("lit_mid_txd",  8'(txd),  8'h01);
    check("lit_mid_tbre", 8'(tbre), 8'h01);
    check("lit_mid_tsre", 8'(tsre), 8'h01);
    @(posedge CLK);
    #1 RST = 1'b1;
    tick(3);
    wr(8'h0F);
    tick(1);
    check("lit_0f_start", 8'(txd), 8'h00);
    tick(FRAME + 10);
    check("lit_0f_done", 8'(tsre), 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
